mux_arb: RTL and testbench

//  - Parametrised N-way, WIDTH-bit selector with valid/ready handshake and a registered output.
//  - Successor to the plain 2:1 datapath mux. Used where several producers share one consumer:

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_arb_rr_pick.sv | 33 +++
 rtl/mux_arb.sv | 105 ++++++++++
 tb/tb_mux_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_arb selector family.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Ceiling log2, used to size channel indices.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Rotating priority encoder: grants the first requester at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    // Upper pass covers ptr..N-1, lower pass wraps around to 0..ptr-1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_vld && req[i] && (SEL_W'(i) >= ptr)) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_vld && req[i] && (SEL_W'(i) < ptr)) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// N-way WIDTH-bit selector with valid/ready handshake and a registered
// output stage. Channel chosen by external select or by round-robin.
module mux_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    logic             w_can_load;
    logic             w_rdy_vld;
    logic             w_gnt_vld;
    logic             w_xfer;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;

    // Output register is empty or draining this cycle.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_xfer     = w_gnt_vld && w_can_load;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;

            rr_pick #(.N(N)) u_pick (
                .req     (in_valid),
                .ptr     (r_ptr),
                .gnt_vld (w_gnt_vld),
                .gnt_idx (w_gnt_idx)
            );

            assign w_rdy_vld = w_gnt_vld;

            // Move the search start just past the channel that was served.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= (32'(w_gnt_idx) == N - 1) ? '0 : w_gnt_idx + SEL_W'(1);
                end
            end
        end else begin : g_sel
            // Selected channel is offered ready even when idle; out-of-range select is inert.
            always_comb begin
                w_rdy_vld = (32'(sel) < N);
                w_gnt_idx = sel;
                w_gnt_vld = 1'b0;
                for (int unsigned i = 0; i < N; i++) begin
                    if ((sel == SEL_W'(i)) && in_valid[i]) begin
                        w_gnt_vld = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Route the granted channel's data and raise its single ready line.
    always_comb begin
        w_gnt_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_gnt_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = w_rdy_vld && w_can_load;
            end
        end
    end

    // Output stage: load on transfer (replacing any draining word), else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_ch    <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: three instances (select N=4, round-robin N=4,
// select N=3) checked every cycle against a behavioural model, plus
// directed literal expectations for the documented scenarios.
module tb_mux_arb;
    import mux_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: 0 = sel4, 1 = rr4, 2 = sel3.
    logic [3:0]   tv    [3];
    logic [127:0] td    [3];
    logic [1:0]   tsel  [3];
    logic         tordy [3];

    logic [3:0]  rdy_s4, rdy_r4;
    logic [2:0]  rdy_s3;
    logic        ov_s4, ov_r4, ov_s3;
    logic [31:0] od_s4, od_r4, od_s3;
    logic [1:0]  och_s4, och_r4, och_s3;

    mux_arb #(.WIDTH(32), .N(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_valid(tv[0]), .in_data(td[0]),
        .in_ready(rdy_s4), .sel(tsel[0]), .out_valid(ov_s4),
        .out_data(od_s4), .out_ch(och_s4), .out_ready(tordy[0])
    );

    mux_arb #(.WIDTH(32), .N(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(tv[1]), .in_data(td[1]),
        .in_ready(rdy_r4), .sel(tsel[1]), .out_valid(ov_r4),
        .out_data(od_r4), .out_ch(och_r4), .out_ready(tordy[1])
    );

    mux_arb #(.WIDTH(32), .N(3), .MODE(MODE_SEL)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_valid(tv[2][2:0]), .in_data(td[2][95:0]),
        .in_ready(rdy_s3), .sel(tsel[2]), .out_valid(ov_s3),
        .out_data(od_s3), .out_ch(och_s3), .out_ready(tordy[2])
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    bit        m_v   [3];
    bit [31:0] m_d   [3];
    int        m_ch  [3];
    int        m_ptr [3];

    function automatic int n_of(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit rr_of(input int k);
        return (k == 1);
    endfunction

    // Channel that wins this cycle, or -1.
    function automatic int pick(input int k, input int ptr);
        int n;
        int c;
        n = n_of(k);
        if (rr_of(k)) begin
            for (int j = 0; j < n; j++) begin
                c = (ptr + j) % n;
                if (tv[k][c]) return c;
            end
            return -1;
        end
        if (int'(tsel[k]) < n && tv[k][tsel[k]]) return int'(tsel[k]);
        return -1;
    endfunction

    // Channel whose ready line may be high this cycle, or -1.
    function automatic int ready_ch(input int k, input int ptr);
        if (rr_of(k)) return pick(k, ptr);
        return (int'(tsel[k]) < n_of(k)) ? int'(tsel[k]) : -1;
    endfunction

    logic [3:0]  a_rdy [3];
    logic        a_ov  [3];
    logic [31:0] a_od  [3];
    logic [1:0]  a_och [3];

    always @(negedge clk) begin
        bit        v;
        bit [31:0] d;
        int        ch, ptr, rc, g;
        bit        can;
        logic [3:0] exp_rdy;

        a_rdy[0] = rdy_s4;          a_rdy[1] = rdy_r4; a_rdy[2] = {1'b0, rdy_s3};
        a_ov[0]  = ov_s4;           a_ov[1]  = ov_r4;  a_ov[2]  = ov_s3;
        a_od[0]  = od_s4;           a_od[1]  = od_r4;  a_od[2]  = od_s3;
        a_och[0] = och_s4;          a_och[1] = och_r4; a_och[2] = och_s3;

        for (int k = 0; k < 3; k++) begin
            v   = rst_n ? m_v[k]   : 1'b0;
            d   = rst_n ? m_d[k]   : 32'd0;
            ch  = rst_n ? m_ch[k]  : 0;
            ptr = rst_n ? m_ptr[k] : 0;

            can     = !v || tordy[k];
            rc      = ready_ch(k, ptr);
            exp_rdy = 4'b0000;
            if (can && rc >= 0) exp_rdy[rc] = 1'b1;

            chk($sformatf("inst%0d in_ready", k), a_rdy[k], exp_rdy);
            chk($sformatf("inst%0d out_valid", k), a_ov[k], v);
            chk($sformatf("inst%0d out_data", k), a_od[k], d);
            chk($sformatf("inst%0d out_ch", k), a_och[k], ch);

            if (!rst_n) begin
                m_v[k]   <= 1'b0;
                m_d[k]   <= '0;
                m_ch[k]  <= 0;
                m_ptr[k] <= 0;
            end else begin
                g = pick(k, ptr);
                if (can && g >= 0) begin
                    m_v[k]  <= 1'b1;
                    m_d[k]  <= td[k][g*32 +: 32];
                    m_ch[k] <= g;
                    if (rr_of(k)) m_ptr[k] <= (g + 1) % n_of(k);
                end else if (tordy[k]) begin
                    m_v[k] <= 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 3; k++) begin
            tv[k] = '0; td[k] = '0; tsel[k] = '0; tordy[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;

        // Select mode, single word from channel 2.
        tsel[0] = 2'd2; tv[0] = 4'b0100; td[0][64 +: 32] = 32'hDEADBEEF; tordy[0] = 1'b1;
        #1 chk("sel4 ready ch2", rdy_s4, 4'b0100);
        cyc();
        chk("sel4 load valid", ov_s4, 1);
        chk("sel4 load data", od_s4, 32'hDEADBEEF);
        chk("sel4 load ch", och_s4, 2);

        // Stall for three cycles with a new word pending.
        tordy[0] = 1'b0; td[0][64 +: 32] = 32'hCAFE0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("sel4 stall ready", rdy_s4, 4'b0000);
            chk("sel4 stall data", od_s4, 32'hDEADBEEF);
            chk("sel4 stall valid", ov_s4, 1);
            cyc();
        end
        tordy[0] = 1'b1;
        #1 chk("sel4 release ready", rdy_s4, 4'b0100);
        cyc();
        chk("sel4 no-bubble valid", ov_s4, 1);
        chk("sel4 no-bubble data", od_s4, 32'hCAFE0001);
        tv[0] = '0;

        // Round-robin, all channels requesting.
        tv[1] = 4'hF; tordy[1] = 1'b1;
        for (int c = 0; c < 4; c++) td[1][c*32 +: 32] = 32'h1000_0000 + c;
        for (int c = 0; c < 7; c++) begin
            cyc();
            chk("rr4 all-valid order", och_r4, c % 4);
            chk("rr4 all-valid data", od_r4, 32'h1000_0000 + (c % 4));
            chk("rr4 all-valid valid", ov_r4, 1);
        end
        // Pointer now at 3; only channels 1 and 3 request.
        tv[1] = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("rr4 wrap order", och_r4, (c % 2 == 0) ? 3 : 1);
        end
        tv[1] = '0;

        // N=3 with out-of-range select.
        tsel[2] = 2'd3; tv[2] = 4'b0111; tordy[2] = 1'b1; td[2] = {32'd0, 96'h3333_3333_2222_2222_1111_1111};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("sel3 oob ready", rdy_s3, 3'b000);
            chk("sel3 oob valid", ov_s3, 0);
            cyc();
        end
        tsel[2] = 2'd2;
        #1 chk("sel3 top ready", rdy_s3, 3'b100);
        cyc();
        chk("sel3 top ch", och_s3, 2);
        chk("sel3 top data", od_s3, 32'h3333_3333);
        tv[2] = '0;

        // Random traffic on all instances.
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                tv[k]    = 4'($urandom);
                if (k == 2) tv[k][3] = 1'b0;
                td[k]    = {$urandom, $urandom, $urandom, $urandom};
                tsel[k]  = 2'($urandom);
                tordy[k] = ($urandom_range(0, 3) != 0);
            end
            cyc();
        end

        // Reset mid-stream with words held in every output register.
        for (int k = 0; k < 3; k++) begin
            tv[k] = 4'b0111; tsel[k] = 2'd1; tordy[k] = 1'b1;
            td[k] = {4{32'h5A5A_1234}};
        end
        cyc();
        chk("pre-reset valid sel4", ov_s4, 1);
        chk("pre-reset valid rr4", ov_r4, 1);
        chk("pre-reset valid sel3", ov_s3, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset valid sel4", ov_s4, 0);
        chk("async reset data sel4", od_s4, 0);
        chk("async reset ch sel4", och_s4, 0);
        chk("async reset valid rr4", ov_r4, 0);
        chk("async reset data rr4", od_r4, 0);
        chk("async reset ch rr4", och_r4, 0);
        chk("async reset valid sel3", ov_s3, 0);
        chk("async reset data sel3", od_s3, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        tv[1] = 4'hF; tordy[1] = 1'b1;
        cyc();
        chk("rr4 ptr zero after reset", och_r4, 0);
        chk("rr4 valid after reset", ov_r4, 1);

        repeat (300) begin
            for (int k = 0; k < 3; k++) begin
                tv[k]    = 4'($urandom);
                if (k == 2) tv[k][3] = 1'b0;
                td[k]    = {$urandom, $urandom, $urandom, $urandom};
                tsel[k]  = 2'($urandom);
                tordy[k] = ($urandom_range(0, 1) != 0);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
